// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks: grid geometry, direction codes,
// prey-generator FSM states and the LFSR feedback mask.
package snake_pkg;

  // Default playfield geometry (coordinates are 0..MAX inclusive)
  localparam int GRID_X_WIDTH = 5;
  localparam int GRID_Y_WIDTH = 5;
  localparam int GRID_X_MAX   = 31;
  localparam int GRID_Y_MAX   = 23;

  // Direction encodings used by the head/body logic
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Prey generator defaults
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  localparam logic [3:0]  DEFAULT_MAX_RETRY = 4'd15;

  // Galois feedback taps for the 16-bit maximal-length LFSR
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_STOP
  } prey_state_e;

endpackage

// File: rtl/snake_lfsr16.sv
// 16-bit Galois LFSR (right shift) with a stall input; a zero seed would lock
// the register at zero, so it is replaced by 1.
module snake_lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] lfsr_o
);

  localparam logic [15:0] SEED_FIXED = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: shift right, fold the feedback mask in when the LSB drops out
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // State register, advances only on enabled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_FIXED;
    end else if (step_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/snake_prey_gen.sv
// Prey placement engine: proposes random cells, checks each against the snake
// body, retries on collision and falls back to a raster scan so that a free
// cell is always found while one exists. All outputs are registered.
module snake_prey_gen
  import snake_pkg::*;
#(
  parameter int          H_LOGIC_WIDTH = GRID_X_WIDTH,
  parameter int          V_LOGIC_WIDTH = GRID_Y_WIDTH,
  parameter int          H_LOGIC_MAX   = GRID_X_MAX,
  parameter int          V_LOGIC_MAX   = GRID_Y_MAX,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_LFSR_SEED,
  parameter logic [3:0]  MAX_RETRY     = DEFAULT_MAX_RETRY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     snake_score,
  input  logic                     snake_lose,
  input  logic [H_LOGIC_WIDTH-1:0] headx,
  input  logic [V_LOGIC_WIDTH-1:0] heady,
  input  logic                     prey_res,
  input  logic                     prey_res_vld,
  output logic [H_LOGIC_WIDTH-1:0] preyx,
  output logic [V_LOGIC_WIDTH-1:0] preyy,
  output logic                     prey_vld,
  output logic                     prey_ready,
  output logic                     board_full
);

  localparam logic [H_LOGIC_WIDTH-1:0] X_MAX  = H_LOGIC_WIDTH'(H_LOGIC_MAX);
  localparam logic [V_LOGIC_WIDTH-1:0] Y_MAX  = V_LOGIC_WIDTH'(V_LOGIC_MAX);
  localparam logic [H_LOGIC_WIDTH-1:0] X_SPAN = H_LOGIC_WIDTH'(H_LOGIC_MAX + 1);
  localparam logic [V_LOGIC_WIDTH-1:0] Y_SPAN = V_LOGIC_WIDTH'(V_LOGIC_MAX + 1);
  localparam logic [H_LOGIC_WIDTH-1:0] X_ONE  = H_LOGIC_WIDTH'(1);
  localparam logic [V_LOGIC_WIDTH-1:0] Y_ONE  = V_LOGIC_WIDTH'(1);
  localparam int                       CELLS  = (H_LOGIC_MAX + 1) * (V_LOGIC_MAX + 1);
  localparam int                       SCAN_W = $clog2(CELLS + 1);
  localparam logic [SCAN_W-1:0]        CELLS_V  = SCAN_W'(CELLS);
  localparam logic [SCAN_W-1:0]        SCAN_ONE = SCAN_W'(1);

  prey_state_e state_q, state_d;
  logic [H_LOGIC_WIDTH-1:0] preyx_q, preyx_d;
  logic [V_LOGIC_WIDTH-1:0] preyy_q, preyy_d;
  logic                     prey_vld_q, prey_vld_d;
  logic                     prey_ready_q, prey_ready_d;
  logic                     board_full_q, board_full_d;
  logic [3:0]               retry_cnt_q, retry_cnt_d;
  logic [SCAN_W-1:0]        scan_cnt_q, scan_cnt_d;
  logic                     scan_mode_q, scan_mode_d;
  logic                     head_hit_q, head_hit_d;

  logic [15:0]              lfsr_w;
  logic                     unused_lfsr;
  logic [H_LOGIC_WIDTH-1:0] raw_x, rand_x, scan_x;
  logic [V_LOGIC_WIDTH-1:0] raw_y, rand_y, scan_y;
  logic                     collide;
  logic                     accept;
  logic                     load;

  snake_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step_i(enb),
    .lfsr_o(lfsr_w)
  );

  // Only some LFSR bits feed the coordinates; the rest are intentionally dropped
  assign unused_lfsr = ^lfsr_w;

  // Candidate sources: folded random cell and raster successor of the last one
  always_comb begin
    raw_x  = lfsr_w[H_LOGIC_WIDTH-1:0];
    raw_y  = lfsr_w[8+V_LOGIC_WIDTH-1:8];
    rand_x = (raw_x > X_MAX) ? raw_x - X_SPAN : raw_x;
    rand_y = (raw_y > Y_MAX) ? raw_y - Y_SPAN : raw_y;
    if (preyx_q == X_MAX) begin
      scan_x = '0;
      scan_y = (preyy_q == Y_MAX) ? '0 : preyy_q + Y_ONE;
    end else begin
      scan_x = preyx_q + X_ONE;
      scan_y = preyy_q;
    end
  end

  // Next-state and registered-output logic of the placement FSM
  always_comb begin
    state_d      = state_q;
    preyx_d      = preyx_q;
    preyy_d      = preyy_q;
    prey_vld_d   = 1'b0;
    prey_ready_d = prey_ready_q;
    board_full_d = board_full_q;
    retry_cnt_d  = retry_cnt_q;
    scan_cnt_d   = scan_cnt_q;
    scan_mode_d  = scan_mode_q;
    head_hit_d   = head_hit_q;
    collide      = 1'b0;
    accept       = 1'b0;
    load         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_GEN;
        load    = 1'b1;
      end
      ST_GEN: begin
        // Head check is resolved here so the request pulse can be registered
        head_hit_d = (preyx_q == headx) && (preyy_q == heady);
        prey_vld_d = !head_hit_d;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        if (head_hit_q) begin
          collide = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (prey_res_vld) begin
          if (prey_res) begin
            collide = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (snake_score) begin
          state_d      = ST_GEN;
          prey_ready_d = 1'b0;
          load         = 1'b1;
        end
      end
      ST_STOP: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (collide) begin
      retry_cnt_d = (retry_cnt_q == MAX_RETRY) ? retry_cnt_q : retry_cnt_q + 4'd1;
      if (scan_mode_q) begin
        scan_cnt_d = scan_cnt_q + SCAN_ONE;
      end
      if (scan_mode_q && (scan_cnt_d == CELLS_V)) begin
        // Every cell has been tried in raster order: nothing is free
        board_full_d = 1'b1;
        state_d      = ST_STOP;
      end else begin
        scan_mode_d = scan_mode_q || (retry_cnt_d == MAX_RETRY);
        state_d     = ST_GEN;
        load        = 1'b1;
      end
    end

    if (accept) begin
      state_d      = ST_HOLD;
      prey_ready_d = 1'b1;
      retry_cnt_d  = '0;
      scan_cnt_d   = '0;
      scan_mode_d  = 1'b0;
    end

    if (load) begin
      preyx_d = scan_mode_d ? scan_x : rand_x;
      preyy_d = scan_mode_d ? scan_y : rand_y;
    end

    // Game over wins over everything else and freezes the visible outputs
    if (snake_lose) begin
      state_d      = ST_STOP;
      preyx_d      = preyx_q;
      preyy_d      = preyy_q;
      prey_vld_d   = 1'b0;
      prey_ready_d = prey_ready_q;
      board_full_d = board_full_q;
      retry_cnt_d  = retry_cnt_q;
      scan_cnt_d   = scan_cnt_q;
      scan_mode_d  = scan_mode_q;
      head_hit_d   = head_hit_q;
    end
  end

  // State and output registers; everything holds while the tick enable is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      preyx_q      <= '0;
      preyy_q      <= '0;
      prey_vld_q   <= 1'b0;
      prey_ready_q <= 1'b0;
      board_full_q <= 1'b0;
      retry_cnt_q  <= '0;
      scan_cnt_q   <= '0;
      scan_mode_q  <= 1'b0;
      head_hit_q   <= 1'b0;
    end else if (enb) begin
      state_q      <= state_d;
      preyx_q      <= preyx_d;
      preyy_q      <= preyy_d;
      prey_vld_q   <= prey_vld_d;
      prey_ready_q <= prey_ready_d;
      board_full_q <= board_full_d;
      retry_cnt_q  <= retry_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_mode_q  <= scan_mode_d;
      head_hit_q   <= head_hit_d;
    end
  end

  assign preyx      = preyx_q;
  assign preyy      = preyy_q;
  assign prey_vld   = prey_vld_q;
  assign prey_ready = prey_ready_q;
  assign board_full = board_full_q;

endmodule

// File: tb/tb_snake_prey_gen.sv
// Directed bench for snake_prey_gen: a cycle table for the first placements,
// then hand-written sequences for retry/scan, head collision, game over,
// mid-search reset and board-full.
module tb_snake_prey_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       snake_score;
  logic       snake_lose;
  logic [4:0] headx;
  logic [4:0] heady;
  logic       prey_res;
  logic       prey_res_vld;
  logic [4:0] preyx;
  logic [4:0] preyy;
  logic       prey_vld;
  logic       prey_ready;
  logic       board_full;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_prey_gen dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .snake_score (snake_score),
    .snake_lose  (snake_lose),
    .headx       (headx),
    .heady       (heady),
    .prey_res    (prey_res),
    .prey_res_vld(prey_res_vld),
    .preyx       (preyx),
    .preyy       (preyy),
    .prey_vld    (prey_vld),
    .prey_ready  (prey_ready),
    .board_full  (board_full)
  );

  // Reference LFSR: Galois, mask B400, reset to ACE1, steps on enabled cycles
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v[0]) lfsr_step = (v >> 1) ^ 16'hB400;
    else      lfsr_step = v >> 1;
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else if (enb) m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic int exp_rx(input logic [15:0] v);
    exp_rx = int'(v[4:0]);
  endfunction

  function automatic int exp_ry(input logic [15:0] v);
    int y;
    y = int'(v[12:8]);
    if (y > 23) y = y - 24;
    exp_ry = y;
  endfunction

  typedef struct {
    logic enb;
    logic score;
    logic lose;
    logic rv;
    logic res;
    int   ex;
    int   ey;
    logic ev;
    logic er;
    logic ef;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic s, input logic l,
                              input logic rv, input logic r, input int ex,
                              input int ey, input logic ev, input logic er,
                              input logic ef);
    vec_t v;
    v.enb = e; v.score = s; v.lose = l; v.rv = rv; v.res = r;
    v.ex = ex; v.ey = ey; v.ev = ev; v.er = er; v.ef = ef;
    mk = v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until a check request is visible
  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (prey_vld) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_vld: prey_vld not seen within 12 cycles");
    end
  endtask

  // Called in the request cycle: answer one cycle later
  task automatic respond(input logic r);
    step();
    prey_res_vld = 1'b1;
    prey_res     = r;
    step();
    prey_res_vld = 1'b0;
    prey_res     = 1'b0;
  endtask

  task automatic next_cell(input int x, input int y, output int nx, output int ny);
    if (x == 31) begin
      nx = 0;
      ny = (y == 23) ? 0 : y + 1;
    end else begin
      nx = x + 1;
      ny = y;
    end
  endtask

  vec_t tbl[12];
  int   cx[17];
  int   cy[17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ex, ey, nx, ny, sx, sy;

    rst = 1'b1; enb = 1'b0; snake_score = 1'b0; snake_lose = 1'b0;
    headx = 5'd0; heady = 5'd31;   // y=31 is off-board: never matches a candidate
    prey_res = 1'b0; prey_res_vld = 1'b0;
    step(); step(); step();
    chk("reset_preyx", int'(preyx), 0);
    chk("reset_preyy", int'(preyy), 0);
    chk("reset_vld", int'(prey_vld), 0);
    chk("reset_ready", int'(prey_ready), 0);
    chk("reset_full", int'(board_full), 0);
    rst = 1'b0;

    // Seed ACE1 -> x = 1, y = 12. After 5 enabled steps LFSR = 0E27 -> (7,14).
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);   // IDLE -> GEN
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 12, 1, 0, 0);   // GEN -> REQ (pulse)
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);   // REQ -> WAIT
    tbl[3]  = mk(1, 0, 0, 1, 0, 1, 12, 0, 1, 0);   // free -> HOLD
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 12, 0, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 1, 12, 0, 1, 0);   // enb low: score lost
    tbl[6]  = mk(1, 1, 0, 0, 0, 7, 14, 0, 0, 0);   // score -> GEN, ready falls
    tbl[7]  = mk(1, 0, 0, 0, 0, 7, 14, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 7, 14, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 7, 14, 0, 0, 0);   // score in WAIT ignored
    tbl[10] = mk(1, 0, 0, 1, 0, 7, 14, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 1, 1, 7, 14, 0, 1, 0);   // res_vld in HOLD ignored

    for (int i = 0; i < 12; i++) begin
      enb = tbl[i].enb; snake_score = tbl[i].score; snake_lose = tbl[i].lose;
      prey_res_vld = tbl[i].rv; prey_res = tbl[i].res;
      step();
      chk($sformatf("vec%0d_preyx", i), int'(preyx), tbl[i].ex);
      chk($sformatf("vec%0d_preyy", i), int'(preyy), tbl[i].ey);
      chk($sformatf("vec%0d_vld", i), int'(prey_vld), int'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), int'(prey_ready), int'(tbl[i].er));
      chk($sformatf("vec%0d_full", i), int'(board_full), int'(tbl[i].ef));
    end
    enb = 1'b1; snake_score = 1'b0; prey_res_vld = 1'b0; prey_res = 1'b0;

    // Fifteen collisions, then the 16th candidate follows the 15th in raster order
    ex = exp_rx(m_lfsr); ey = exp_ry(m_lfsr);
    snake_score = 1'b1; step(); snake_score = 1'b0;
    chk("retry_c1_x", int'(preyx), ex);
    chk("retry_c1_y", int'(preyy), ey);
    for (int k = 1; k <= 16; k++) begin
      wait_vld(ok);
      if (!ok) break;
      cx[k] = int'(preyx); cy[k] = int'(preyy);
      if (k < 16) respond(1'b1);
    end
    next_cell(cx[15], cy[15], nx, ny);
    chk("scan_c16_x", cx[16], nx);
    chk("scan_c16_y", cy[16], ny);
    respond(1'b0);
    chk("scan_accept_ready", int'(prey_ready), 1);

    // The following score must be back in random mode
    ex = exp_rx(m_lfsr); ey = exp_ry(m_lfsr);
    snake_score = 1'b1; step(); snake_score = 1'b0;
    chk("rand_after_scan_x", int'(preyx), ex);
    chk("rand_after_scan_y", int'(preyy), ey);
    wait_vld(ok);
    respond(1'b0);
    chk("rand_accept_ready", int'(prey_ready), 1);

    // Head sits on the next candidate: no request, new candidate 2 cycles on
    ex = exp_rx(m_lfsr); ey = exp_ry(m_lfsr);
    headx = 5'(ex); heady = 5'(ey);
    snake_score = 1'b1; step(); snake_score = 1'b0;
    chk("head_cand_x", int'(preyx), ex);
    chk("head_cand_y", int'(preyy), ey);
    step();
    chk("head_no_vld", int'(prey_vld), 0);
    ex = exp_rx(m_lfsr); ey = exp_ry(m_lfsr);
    step();
    headx = 5'd0; heady = 5'd31;
    chk("head_new_x", int'(preyx), ex);
    chk("head_new_y", int'(preyy), ey);
    step();
    chk("head_new_vld", int'(prey_vld), 1);
    respond(1'b0);
    chk("head_accept_ready", int'(prey_ready), 1);

    // Score and lose together in HOLD: lose wins, everything freezes
    sx = int'(preyx); sy = int'(preyy);
    snake_score = 1'b1; snake_lose = 1'b1; step();
    snake_lose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stop%0d_ready", i), int'(prey_ready), 1);
      chk($sformatf("stop%0d_vld", i), int'(prey_vld), 0);
      chk($sformatf("stop%0d_preyx", i), int'(preyx), sx);
      chk($sformatf("stop%0d_preyy", i), int'(preyy), sy);
      step();
    end
    snake_score = 1'b0;

    // Reset out of STOP, then again while waiting for a result
    rst = 1'b1; step(); rst = 1'b0;
    wait_vld(ok);
    chk("rst_first_x", int'(preyx), 1);
    chk("rst_first_y", int'(preyy), 12);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_wait_preyx", int'(preyx), 0);
    chk("rst_wait_preyy", int'(preyy), 0);
    chk("rst_wait_vld", int'(prey_vld), 0);
    chk("rst_wait_ready", int'(prey_ready), 0);
    prey_res_vld = 1'b1; prey_res = 1'b0; step();
    prey_res_vld = 1'b0;
    chk("stale_res_ready", int'(prey_ready), 0);
    chk("stale_res_x", int'(preyx), 1);
    chk("stale_res_y", int'(preyy), 12);
    wait_vld(ok);
    chk("restart_x", int'(preyx), 1);
    chk("restart_y", int'(preyy), 12);

    // Every check collides: 15 random retries plus 768 scan cells -> board full
    for (int n = 1; n <= 783; n++) begin
      if (n > 1) begin
        wait_vld(ok);
        if (!ok) break;
      end
      if (n == 783) chk("full_before_last", int'(board_full), 0);
      respond(1'b1);
    end
    chk("board_full_set", int'(board_full), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("full%0d_vld", i), int'(prey_vld), 0);
      chk($sformatf("full%0d_flag", i), int'(board_full), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_prey_gen.md
# snake_prey_gen

Prey placement engine for the snake game, sitting directly upstream of the snake body tracker. It proposes pseudo-random prey cells, issues one occupancy check per candidate against the snake-body FIFO, retries on collision, and holds an accepted prey until the body reports a score. After repeated collisions it switches to a deterministic raster scan. The scan guarantees termination while any free cell exists.

## Interface
Parameters:
- H_LOGIC_WIDTH, 5, x coordinate width
- V_LOGIC_WIDTH, 5, y coordinate width
- H_LOGIC_MAX, 31, last legal x
- V_LOGIC_MAX, 23, last legal y
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001
- MAX_RETRY, 4'd15, consecutive collisions before switching to scan mode

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enb  in  1  game tick enable; when low, the FSM and LFSR freeze
- snake_score  in  1  head reached the prey
- snake_lose  in  1  game over
- headx  in  H_LOGIC_WIDTH  current snake head x
- heady  in  V_LOGIC_WIDTH  current snake head y
- prey_res  in  1  check result; 1 = cell occupied by the body
- prey_res_vld  in  1  qualifies prey_res
- preyx  out  H_LOGIC_WIDTH  candidate or accepted prey x
- preyy  out  V_LOGIC_WIDTH  candidate or accepted prey y
- prey_vld  out  1  one-cycle check request for {preyx, preyy}
- prey_ready  out  1  prey is accepted and may be drawn
- board_full  out  1  sticky; no free cell found

## Operation
States: IDLE, GEN, REQ, WAIT, HOLD, STOP.
- IDLE: goes to GEN on the first cycle with enb=1.
- GEN: loads the candidate into preyx/preyy.
  - Random mode: x = lfsr[H_LOGIC_WIDTH-1:0]; y = lfsr[8+V_LOGIC_WIDTH-1:8].
  - Range fold: any value > MAX has MAX+1 subtracted (e.g. y = 26 → 2).
  - Scan mode: candidate = previous candidate + 1 along x. At x = H_LOGIC_MAX, x wraps to 0 and y increments. At (H_LOGIC_MAX, V_LOGIC_MAX), the candidate wraps to (0,0).
- REQ: if the candidate equals {headx, heady}, it counts as a collision and the FSM returns to GEN without asserting prey_vld. Otherwise prey_vld = 1 for exactly this cycle, then WAIT.
- WAIT: holds preyx/preyy stable until prey_res_vld.
  - prey_res = 1: increment retry_cnt and scan_cnt, then GEN.
  - prey_res = 0: HOLD.
  - The wait is unbounded.
- Mode switch: when retry_cnt reaches MAX_RETRY, scan mode is set until the next HOLD entry.
- board_full: when scan_cnt reaches (H_LOGIC_MAX+1)*(V_LOGIC_MAX+1) in scan mode (768 with defaults; 10-bit counter), set board_full and go to STOP.
- HOLD: prey_ready = 1. Entering HOLD clears retry_cnt, scan_cnt and scan mode. snake_score goes to GEN.
- Game over: snake_lose in any state goes to STOP. snake_lose takes priority over a simultaneous snake_score.
- STOP: absorbing; only rst leaves it. Outputs hold their last values, except prey_vld = 0.
- Ignored inputs: snake_score outside HOLD; prey_res_vld outside WAIT.
- LFSR: 16-bit Galois, mask 16'hB400, steps every enb cycle in every state, including HOLD, for entropy.

## Timing
- Reset values:
  - state = IDLE
  - preyx = 0, preyy = 0
  - prey_vld = 0, prey_ready = 0, board_full = 0
  - lfsr = LFSR_SEED
  - counters = 0
- rst mid-search drops any outstanding check and returns to IDLE; a late prey_res_vld is ignored.
- All outputs are registered.
- Score-to-ready latency with res_vld returned one cycle after the request:
  - snake_score high in HOLD at cycle t
  - candidate valid at t+1
  - prey_vld at t+2
  - res_vld at t+3
  - prey_ready at t+4
- prey_ready falls at t+1.
- A head collision in REQ costs 2 cycles per retry.
- While enb = 0 every register holds. A prey_res_vld arriving while enb = 0 is lost, so the body must be stalled by the same enb.

## Structure
- Package snake_pkg holds the grid constants, the DIR_* encodings, the FSM state enum, and LFSR_MASK.
- Sub-module: snake_lfsr16, containing the seed fix-up and the step enable.
- Everything else stays in a single FSM module, roughly 200 lines.

## Test plan
- Reset, enb=1, prey_res_vld with res=0 one cycle after each request → exactly one prey_vld pulse; prey_ready at cycle 4; preyx/preyy equal the folded LFSR_SEED bits.
- Responder returns res=1 fifteen times → the 16th candidate equals the 15th candidate + 1 (raster order); res=0 then gives prey_ready, and a later score restarts in random mode.
- headx/heady forced to equal the next candidate → no prey_vld for that candidate; a new candidate appears 2 cycles later.
- Responder always returns res=1 → after 15 + 768 collisions, board_full = 1, state STOP, prey_vld stays 0.
- snake_score and snake_lose in the same HOLD cycle → STOP, prey_ready held, no new request; snake_score during WAIT → ignored.
- rst asserted in WAIT, then a stale prey_res_vld → ignored; IDLE, outputs zero; the sequence restarts from LFSR_SEED.
